uart_rx_buf: RTL and testbench

//  UART receiver with a receive FIFO. It deserialises 8N1 frames from the serial input line.
//  It sits directly downstream of the `tx` serialiser and forms the receive path of the toy MCU UART.

---
 rtl/uart_rx_buf_pkg.sv | 28 ++
 rtl/uart_rx_buf_fifo.sv | 87 ++++++++
 rtl/uart_rx_buf.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_buf.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_buf_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_buf_pkg
// Shared definitions for the toy MCU UART receive path: receiver FSM state
// encoding, frame data width and default parameter values. The transmit
// serialiser uses the same package so both ends agree on framing and baud.
// Ports: none (package only).
// ----------------------------------------------------------------------------
package uart_rx_buf_pkg;

    // Payload bits per 8N1 frame
    localparam int DATA_BITS = 8;

    // Clocks per bit period; the transmitter must use the same value
    localparam int DEFAULT_BAUD_DIV = 16;

    // Receive FIFO entries
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Receiver FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rxState_e;

endpackage

// File: rtl/uart_rx_buf_fifo.sv
// ----------------------------------------------------------------------------
// rx_fifo
// Synchronous first-word-fall-through FIFO for received bytes. The head entry
// is presented on dout_o whenever the FIFO is not empty; a pop advances it.
// A push while full is only accepted when a pop happens in the same cycle, so
// occupancy never exceeds FIFO_DEPTH and stored contents are never overwritten.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset, empties the FIFO
//   push_i   write din_i this cycle
//   din_i    data to write
//   pop_i    consumer takes the head entry (ignored while empty)
//   dout_o   head entry, reads 0 while empty
//   empty_o  no entries stored
//   full_o   FIFO_DEPTH entries stored
// ----------------------------------------------------------------------------
module rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wrPtr_q;
    logic [AW:0]      wrPtr_d;
    logic [AW:0]      rdPtr_q;
    logic [AW:0]      rdPtr_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             doPush;
    logic             doPop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // low bits with differing wrap bits mean full.
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a push when the consumer is reading.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Head of queue falls through; forced to zero while empty so the read
    // port shows a clean value after reset.
    assign dout_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

    // Next pointer values, advancing with natural wrap
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
    end

    // Pointer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage is not reset; empty_o masks stale entries
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/uart_rx_buf.sv
// ----------------------------------------------------------------------------
// uart_rx_buf
// 8N1 UART receiver with a receive FIFO. The serial line is synchronised,
// frames are sampled mid-bit using a down-counting baud counter, and good
// bytes are pushed into a first-word-fall-through FIFO read by the core via a
// valid/ready port. Framing errors and overruns are single-cycle pulses.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   rx_i         serial line, idles high, asynchronous to clk_i
//   rd_data_o    head of the FIFO, valid while rd_valid_o is high
//   rd_valid_o   FIFO not empty
//   rd_ready_i   consumer accepts rd_data_o (pop when valid && ready)
//   frame_err_o  pulse: stop bit sampled low
//   overrun_o    pulse: good byte dropped because the FIFO was full
//   busy_o       receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx_buf
    import uart_rx_buf_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W - 1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = {{(BIT_W - 1){1'b0}}, 1'b1};

    logic                 rxMeta_q;
    logic                 rxSync_q;
    rxState_e             state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bitIdx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frameErr_q;
    logic                 overrun_q;

    logic                 cntZero;
    logic                 stopSample;
    logic                 pushReq;
    logic                 popReq;
    logic                 fifoEmpty;
    logic                 fifoFull;

    // Two-flop synchroniser; both stages preset to the idle level so reset
    // never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx_i;
            rxSync_q <= rxMeta_q;
        end
    end

    assign cntZero    = (cnt_q == '0);
    assign stopSample = (state_q == RX_STOP) && cntZero;

    // A good stop bit hands the assembled byte straight to the FIFO in the
    // sampling cycle, so rd_valid rises the cycle after the stop sample.
    assign pushReq = stopSample && rxSync_q;
    assign popReq  = rd_valid_o && rd_ready_i;

    // Receiver FSM with baud counter, bit index, shift register and the
    // registered error pulses. The counter only runs in START/DATA/STOP and
    // is reloaded whenever a sample is taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            overrun_q  <= pushReq && fifoFull && !popReq;
            case (state_q)
                RX_IDLE: begin
                    if (!rxSync_q) begin
                        cnt_q   <= HALF_LOAD;
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cntZero) begin
                        if (!rxSync_q) begin
                            cnt_q    <= FULL_LOAD;
                            bitIdx_q <= '0;
                            state_q  <= RX_DATA;
                        end else begin
                            state_q <= RX_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cntZero) begin
                        shift_q <= {rxSync_q, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= FULL_LOAD;
                        if (bitIdx_q == LAST_BIT) begin
                            state_q <= RX_STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + BIT_ONE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cntZero) begin
                        if (rxSync_q) begin
                            state_q <= RX_IDLE;
                        end else begin
                            frameErr_q <= 1'b1;
                            state_q    <= RX_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RX_BREAK: begin
                    if (rxSync_q) begin
                        state_q <= RX_IDLE;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                end
            endcase
        end
    end

    rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (DATA_BITS)
    ) uFifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pushReq),
        .din_i   (shift_q),
        .pop_i   (popReq),
        .dout_o  (rd_data_o),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull)
    );

    assign rd_valid_o  = !fifoEmpty;
    assign frame_err_o = frameErr_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_buf.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_buf
// Drives 8N1 frames into uart_rx_buf and checks received bytes and error
// pulses against a capacity-limited FIFO model through a scoreboard.
// ----------------------------------------------------------------------------
module tb_uart_rx_buf;

    localparam int BAUD  = 16;
    localparam int DEPTH = 4;

    localparam int EV_FE  = 1;
    localparam int EV_OVR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_ready = 1'b1;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic [7:0] expQ[$];
    int         expFlagQ[$];
    int         checks = 0;
    int         errors = 0;
    int         occ = 0;
    int         lat = 0;
    logic       sawBusy;

    uart_rx_buf #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .rd_ready_i  (rd_ready),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Single comparison with reporting
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Event seen with nothing expected
    task automatic reportUnexpected(input string name, input logic [31:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, actual);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold one bit level on the line for a full bit period
    task automatic driveBit(input logic b);
        rx = b;
        repeat (BAUD) @(posedge clk);
        #1;
    endtask

    // Serialise one 8N1 frame; the line is left at the stop level
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            driveBit(data[i]);
        end
        driveBit(stopBit);
    endtask

    // Send a good frame and predict its fate with a bounded-FIFO model
    task automatic sendGood(input logic [7:0] d);
        if (!rd_ready && occ == DEPTH) begin
            expFlagQ.push_back(EV_OVR);
        end else begin
            expQ.push_back(d);
            if (!rd_ready) occ++;
        end
        applyStimulus(d, 1'b1);
        idle(2);
    endtask

    task automatic drain();
        int waited;
        rd_ready = 1'b1;
        waited = 0;
        while (rd_valid && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("drain_empty", {31'd0, rd_valid}, 32'd0);
        occ = 0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        checkOutput({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        checkOutput({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
    endtask

    // Scoreboard monitor: compares every accepted byte and every error pulse
    // against the expectations queued by the stimulus.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid && rd_ready) begin
                if (expQ.size() == 0) reportUnexpected("rd_data_unexpected", {24'd0, rd_data});
                else checkOutput("rd_data", {24'd0, rd_data}, {24'd0, expQ.pop_front()});
            end
            if (frame_err || overrun) begin
                checkOutput("flag_exclusive", {31'd0, frame_err && overrun}, 32'd0);
                if (expFlagQ.size() == 0)
                    reportUnexpected("flag_unexpected", frame_err ? EV_FE : EV_OVR);
                else
                    checkOutput("flag_event", frame_err ? EV_FE : EV_OVR, expFlagQ.pop_front());
            end
        end
    end

    // Stimulus sequence
    initial begin
        rst = 1'b1;
        rx = 1'b1;
        rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("por");
        rst = 1'b0;
        idle(3);

        // Single byte with latency from start detection to rd_valid
        expQ.push_back(8'h41);
        fork
            applyStimulus(8'h41, 1'b1);
            begin
                lat = 0;
                while (lat < 300) begin
                    @(posedge clk);
                    #1;
                    lat++;
                    if (rd_valid) break;
                end
            end
        join
        checkOutput("latency_t0_to_valid", lat - 2, 32'd153);
        idle(5);

        // Short low glitch: false start
        sawBusy = 1'b0;
        rx = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (busy) sawBusy = 1'b1;
        end
        rx = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (busy) sawBusy = 1'b1;
        end
        checkOutput("false_start_busy_seen", {31'd0, sawBusy}, 32'd1);
        checkOutput("false_start_idle", {31'd0, busy}, 32'd0);
        checkOutput("false_start_no_data", {31'd0, rd_valid}, 32'd0);

        // Framing error followed by a long break
        expFlagQ.push_back(EV_FE);
        applyStimulus(8'h55, 1'b0);
        idle(400);
        rx = 1'b1;
        idle(40);
        checkOutput("break_fifo_empty", {31'd0, rd_valid}, 32'd0);
        checkOutput("break_idle", {31'd0, busy}, 32'd0);

        // Overrun: five bytes into a four-entry FIFO with no reads
        rd_ready = 1'b0;
        for (int v = 1; v <= 5; v++) sendGood(v[7:0]);
        checkOutput("overrun_fifo_full", {31'd0, rd_valid}, 32'd1);
        drain();

        // Full FIFO with a pop in the same cycle as the fifth push
        rd_ready = 1'b0;
        for (int v = 1; v <= 4; v++) sendGood(v[7:0]);
        expQ.push_back(8'h05);
        fork
            applyStimulus(8'h05, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                rd_ready = 1'b1;
                @(posedge clk);
                #1;
                rd_ready = 1'b0;
            end
        join
        idle(2);
        drain();

        // Reset in the middle of a frame, then a clean frame
        rd_ready = 1'b1;
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        driveBit(1'b0);
        rst = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        checkResetOutputs("midrst");
        rst = 1'b0;
        idle(20);
        sendGood(8'hA5);
        idle(5);

        // Random bytes with random idle gaps, reader always ready
        for (int i = 0; i < 12; i++) begin
            sendGood(8'($urandom_range(0, 255)));
            idle(1 + $urandom_range(0, 4));
        end

        // Random-length burst with the reader stalled
        begin
            int k;
            k = $urandom_range(2, 7);
            rd_ready = 1'b0;
            for (int i = 0; i < k; i++) sendGood(8'($urandom_range(0, 255)));
            drain();
        end

        idle(10);
        checkOutput("bytes_outstanding", expQ.size(), 32'd0);
        checkOutput("flags_outstanding", expFlagQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
